// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, request, bit shifting and ACK capture
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_noack,
  output logic       err_timeout
);
  localparam int CMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      sh_q, sh_d;
  logic            dat_q, dat_d;
  logic            nack_q, nack_d;
  logic            ack_ok_q, ack_ok_d;
  logic            err_noack_q, err_noack_d;
  logic            err_timeout_q, err_timeout_d;

  logic [1:0]      pad, s1_q, s2_q, filt_q;
  logic [FW-1:0]   fcnt_q [2];
  logic            prev_clk_q;
  logic            fall, timed;

  assign pad = {ps2_dat_in, ps2_clk_in};

  // Synchronize both pads and only accept a level change after FILTER_LEN equal samples (index 0 = clock, 1 = data)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 2'b11;
      s2_q       <= 2'b11;
      filt_q     <= 2'b11;
      prev_clk_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      s1_q       <= pad;
      s2_q       <= s1_q;
      prev_clk_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) fcnt_q[i] <= '0;
        else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          fcnt_q[i] <= '0;
        end else fcnt_q[i] <= fcnt_q[i] + 1'b1;
      end
    end
  end

  assign fall  = prev_clk_q & ~filt_q[0];
  assign timed = state_q == SEND || state_q == ACK || state_q == WAIT_IDLE;

  // State and frame registers; async reset drops both open-drain enables immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      sh_q          <= '0;
      dat_q         <= 1'b0;
      nack_q        <= 1'b0;
      ack_ok_q      <= 1'b0;
      err_noack_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      sh_q          <= sh_d;
      dat_q         <= dat_d;
      nack_q        <= nack_d;
      ack_ok_q      <= ack_ok_d;
      err_noack_q   <= err_noack_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state: the shift register holds {stop, parity, data} so every falling edge simply drives its LSB
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    sh_d          = sh_q;
    dat_d         = dat_q;
    nack_d        = nack_q;
    ack_ok_d      = ack_ok_q;
    err_noack_d   = err_noack_q;
    err_timeout_d = err_timeout_q;
    done          = 1'b0;
    if (timed) cnt_d = fall ? '0 : (cnt_q == CW'(TIMEOUT_CYC) ? cnt_q : cnt_q + 1'b1);
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d       = INHIBIT;
        cnt_d         = '0;
        bit_d         = '0;
        sh_d          = {1'b1, ~^tx_data, tx_data};
        nack_d        = 1'b0;
        ack_ok_d      = 1'b0;
        err_noack_d   = 1'b0;
        err_timeout_d = 1'b0;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        state_d = SEND;
        cnt_d   = '0;
        dat_d   = 1'b1;
        bit_d   = '0;
      end
      SEND: if (fall) begin
        dat_d = ~sh_q[0];
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd9) state_d = ACK;
      end
      ACK: if (fall) begin
        nack_d  = filt_q[1];
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (filt_q[0] && filt_q[1]) begin
        done        = 1'b1;
        ack_ok_d    = ~nack_q;
        err_noack_d = nack_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timed && !fall && !done && cnt_q >= CW'(TIMEOUT_CYC - 1)) begin
      state_d       = IDLE;
      done          = 1'b1;
      ack_ok_d      = 1'b0;
      err_noack_d   = 1'b0;
      err_timeout_d = 1'b1;
    end
  end

  assign tx_ready    = state_q == IDLE;
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = state_q == INHIBIT || state_q == REQ;
  assign ps2_dat_oe  = state_q == REQ || (state_q == SEND && dat_q);
  assign ack_ok      = ack_ok_q;
  assign err_noack   = err_noack_q;
  assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model driving the open-drain lines
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO  = 200;
  localparam int FL  = 4;
  localparam int H   = 20;

  logic clk = 0, reset = 1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 0;
  logic dev_clk = 1, dev_dat = 1;
  logic tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic busy, done, ack_ok, err_noack, err_timeout;

  typedef struct {logic [10:0] frame; logic [1:0] res;} exp_t;
  exp_t exp_q[$];
  logic [10:0] rx_q[$];
  exp_t e;
  int errors = 0, checks = 0;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err_noack(err_noack), .err_timeout(err_timeout)
  );

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected outcome
  initial forever begin
    @(negedge clk);
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        @(negedge clk);
        check("ack_ok", ack_ok, e.res == 2'd0);
        check("err_noack", err_noack, e.res == 2'd1);
        check("err_timeout", err_timeout, e.res == 2'd2);
        check("ready_after_done", tx_ready, 1);
        if (e.res != 2'd2) begin
          check("frame_present", rx_q.size(), 1);
          if (rx_q.size() != 0) check("frame", rx_q.pop_front(), e.frame);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic [10:0] fr, input logic [1:0] res, input bit track);
    int n = 0, r = 0;
    if (track) exp_q.push_back('{fr, res});
    @(negedge clk);
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    check("busy_after_accept", {busy, tx_ready}, 2'b10);
    while (ps2_clk_oe && n < 1000) begin
      n++;
      if (ps2_dat_oe) r++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH + 1);
    check("req_len", r, 1);
    check("start_driven", ps2_dat_oe, 1);
  endtask

  task automatic device(input int edges, input bit do_ack, input bit glitch, input bit poke);
    logic [10:0] f = '0;
    repeat (10) @(negedge clk);
    f[0] = ps2_dat_in;
    for (int k = 1; k <= edges; k++) begin
      dev_clk = 0;
      repeat (H) @(negedge clk);
      dev_clk = 1;
      f[k] = ps2_dat_in;
      if (poke && k == 5) begin
        tx_data = 8'h55;
        tx_valid = 1;
        repeat (2) @(negedge clk);
        tx_valid = 0;
        repeat (H - 2) @(negedge clk);
      end else if (glitch) begin
        repeat (5) @(negedge clk);
        dev_clk = 0;
        repeat (2) @(negedge clk);
        dev_clk = 1;
        repeat (H - 7) @(negedge clk);
      end else repeat (H) @(negedge clk);
    end
    if (edges < 10) return;
    rx_q.push_back(f);
    if (do_ack) dev_dat = 0;
    repeat (H / 2) @(negedge clk);
    dev_clk = 0;
    repeat (H) @(negedge clk);
    dev_clk = 1;
    dev_dat = 1;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_ready, busy, done, ps2_clk_oe, ps2_dat_oe}, 5'b10000);
    check("reset_flags", {ack_ok, err_noack, err_timeout}, 3'b000);
    reset = 0;
    repeat (3) @(negedge clk);
    send(8'hED, {2'b11, 8'hED, 1'b0}, 2'd0, 1);
    device(10, 1, 0, 0);
    drain("drain_ed");
    send(8'h00, {2'b11, 8'h00, 1'b0}, 2'd1, 1);
    device(10, 0, 0, 0);
    drain("drain_00");
    send(8'hFF, 11'h0, 2'd2, 1);
    n = 0;
    while (ps2_dat_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_len", n, TO);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    drain("drain_ff");
    send(8'hA5, 11'h0, 2'd0, 0);
    device(4, 0, 0, 0);
    reset = 1;
    #1;
    check("reset_midframe_oe", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);
    send(8'hF4, {2'b10, 8'hF4, 1'b0}, 2'd0, 1);
    device(10, 1, 0, 0);
    drain("drain_f4");
    send(8'hC3, {2'b11, 8'hC3, 1'b0}, 2'd0, 1);
    device(10, 1, 1, 0);
    drain("drain_glitch");
    send(8'h3C, {2'b11, 8'h3C, 1'b0}, 2'd0, 1);
    device(10, 1, 0, 1);
    drain("drain_poke");
    repeat (100) @(negedge clk);
    check("idle_at_end", {tx_ready, busy}, 2'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
